img_uart_loader: RTL
====================

# img_uart_loader

Receives a 28×28 8-bit grayscale image over a UART 8N1 serial line and assembles it into the 6272-bit packed `img_data` bus consumed by the MNIST accelerator. It replaces the hard-coded BRAM test image in the top level. After a complete frame with a valid checksum, it issues a one-cycle `start` pulse to the accelerator. Malformed frames are discarded and flagged; the accelerator is never started on them.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200 baud).
- `IMG_SIZE`, 784: pixel bytes per frame.
- `SYNC_BYTE`, 8'hA5: frame header byte.
- `TIMEOUT_CLKS`, 1_000_000: maximum idle cycles between bytes inside a frame.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: UART receive line; idles high; asynchronous to `clk`.
- `img_data`, out, 6272: packed image; pixel k occupies `[k*8 +: 8]`.
- `start`, out, 1: one-cycle pulse to the accelerator; asserted only on a good frame.
- `img_valid`, out, 1: high while `img_data` holds a complete, checksum-good image.
- `frame_err`, out, 1: sticky error flag; cleared on the next accepted sync byte.
- `byte_cnt`, out, 10: number of pixels received in the current frame (debug/LED use).

## Operation
- Frame format: `SYNC_BYTE`, then `IMG_SIZE` pixel bytes, then a checksum byte equal to the XOR of all pixel bytes.
- Sub-module `uart_rx`:
  - `rx` passes through a 2-FF synchronizer.
  - Falling edge starts reception; the start bit is re-checked at its half-bit point and a glitch returns to idle.
  - Data bits are sampled LSB-first at mid-bit.
  - Stop bit is sampled at mid-bit. It emits `rx_byte` plus a one-cycle `rx_valid`, or a one-cycle `rx_ferr` if the stop bit is 0.
- FSM states: IDLE, RECV, CHK, FIRE.
- IDLE:
  - `rx_valid` with a byte equal to `SYNC_BYTE` → RECV; clear `byte_cnt`, the running XOR, `img_valid` and `frame_err`.
  - Any other byte is ignored.
- RECV, on `rx_valid`:
  - Write the byte into `img_data[byte_cnt*8 +: 8]`, XOR it into the checksum, and increment `byte_cnt`.
  - When `byte_cnt` reaches `IMG_SIZE`-1 and that byte is written → CHK.
- CHK, on `rx_valid`:
  - Byte equals the running XOR → FIRE.
  - Otherwise set `frame_err` and → IDLE.
- FIRE: assert `start` and `img_valid` for one cycle, then → IDLE. `img_valid` stays high afterwards.
- Abort conditions, in RECV or CHK:
  - `rx_ferr` → IDLE, `frame_err`=1.
  - Inactivity counter reaching `TIMEOUT_CLKS` → IDLE, `frame_err`=1.
  - The inactivity counter resets on every `rx_valid` and whenever the FSM is in IDLE.
- Aborted frames leave partial data in `img_data`. `img_valid` is already 0 at that point because it was cleared at sync.
- A sync byte value appearing inside RECV is treated as pixel data, never as a restart.
- The byte index never exceeds `IMG_SIZE`-1, so `img_data` writes have no wrap-around.

## Timing
- Reset values (async, `rst`=0): `img_data`=0, `start`=0, `img_valid`=0, `frame_err`=0, `byte_cnt`=0, FSM=IDLE, `uart_rx` idle.
- `rx_valid` asserts on the cycle after the stop-bit mid-sample. Latency from the `rx` falling edge is ≈ 9.5×`CLKS_PER_BIT` + 3 cycles, including the synchronizer.
- A pixel write is visible on `img_data` in the cycle after its `rx_valid`.
- `start` is high exactly one cycle, two cycles after the checksum byte's `rx_valid` (CHK→FIRE registration, then FIRE output). `img_data` is stable from that point until the next sync byte.
- Reset mid-frame: everything returns to reset values immediately and no `start` pulse is produced. Reception restarts only on a fresh sync byte after deassertion.
- If `rx_valid` and the timeout terminal count fall in the same cycle, the byte wins and the counter resets.
- Back-to-back frames with no gap are supported. `start` is not gated by accelerator status; the host must not send a new frame before `done`.

## Structure
- Shared package/header: `IMG_SIZE`, `SYNC_BYTE`, the FSM state encoding (2-bit localparams), and `IMG_BITS` = `IMG_SIZE`*8.
- One sub-module: `uart_rx` (synchronizer, bit timer, shift register), parameterized by `CLKS_PER_BIT`.
- The top level is FSM plus datapath only. The image lives in `img_data` flops, matching the accelerator's packed input.

## Test plan
- Good frame, pixels k=0..783 equal to k mod 256, checksum 8'h00 → one `start` pulse; `img_data[400*8 +: 8]`=8'h90; `img_valid`=1; `frame_err`=0.
- Same frame with checksum 8'h01 → no `start`; `frame_err`=1; `img_valid`=0; FSM back in IDLE.
- Garbage bytes 8'h00, 8'hFF before the sync byte, then a good frame → the garbage is ignored and exactly one `start` follows.
- Stop bit forced 0 on pixel 100 → abort with `frame_err`=1 and `byte_cnt`=100; a following good frame clears `frame_err` and fires `start`.
- Send 500 pixels then go silent for `TIMEOUT_CLKS` cycles → `frame_err`=1 and no `start`. Separately, `rst` pulsed low at pixel 300 → all outputs return to 0 immediately.
- 1-cycle low glitch on `rx` while idle → no `rx_valid`; state unchanged.

Source files
------------

// File: rtl/img_uart_loader_pkg.sv
// Shared constants, state encodings and types for the UART image loader.
package img_uart_loader_pkg;

    localparam int         IMG_SIZE  = 784;
    localparam int         IMG_BITS  = IMG_SIZE * 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_CHK  = 2'd2;
    localparam logic [1:0] ST_FIRE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RECV = ST_RECV,
        S_CHK  = ST_CHK,
        S_FIRE = ST_FIRE
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/img_uart_loader_uart_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, mid-bit sampling, LSB-first shift.
module uart_rx
    import img_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int            CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'((CLKS_PER_BIT / 2) - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;

    assign rx_s     = sync_q[1];
    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rx};
        prev_d  = rx_s;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // a start bit that is high again at its centre was a glitch
                    if (!rx_s) begin
                        state_d = RX_DATA;
                        cnt_d   = FULL_LOAD;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: rtl/img_uart_loader.sv
// Frame loader: sync byte, IMG_SIZE pixels, XOR checksum -> packed img_data + start pulse.
// state | meaning
// IDLE  | hunting for SYNC_BYTE
// RECV  | storing pixel bytes
// CHK   | awaiting checksum byte
// FIRE  | good frame, pulse start
module img_uart_loader
    import img_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [IMG_BITS-1:0] img_data,
    output logic                start,
    output logic                img_valid,
    output logic                frame_err,
    output logic [9:0]          byte_cnt
);

    localparam int            TW       = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLKS - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    state_e              state_q, state_d;
    logic [IMG_BITS-1:0] img_data_q, img_data_d;
    logic [9:0]          byte_cnt_q, byte_cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                start_q, start_d;
    logic                img_valid_q, img_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                in_frame;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst_n    (rst),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign img_data  = img_data_q;
    assign start     = start_q;
    assign img_valid = img_valid_q;
    assign frame_err = frame_err_q;
    assign byte_cnt  = byte_cnt_q;
    assign in_frame  = (state_q == S_RECV) || (state_q == S_CHK);

    always_comb begin
        state_d     = state_q;
        img_data_d  = img_data_q;
        byte_cnt_d  = byte_cnt_q;
        csum_d      = csum_q;
        tmo_d       = tmo_q;
        start_d     = 1'b0;
        img_valid_d = img_valid_q;
        frame_err_d = frame_err_q;

        if (state_q == S_IDLE || rx_valid) tmo_d = TMO_LOAD;
        else if (tmo_q != '0)              tmo_d = tmo_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d     = S_RECV;
                    byte_cnt_d  = 10'd0;
                    csum_d      = 8'h00;
                    img_valid_d = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    img_data_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
                    csum_d     = csum_q ^ rx_byte;
                    byte_cnt_d = byte_cnt_q + 10'd1;
                    if (byte_cnt_q == 10'(IMG_SIZE - 1)) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_byte == csum_q) begin
                        state_d = S_FIRE;
                    end else begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_FIRE: begin
                start_d     = 1'b1;
                img_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // a byte landing on the timeout terminal count takes priority
        if (in_frame && !rx_valid && (rx_ferr || tmo_q == '0)) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            img_data_q  <= '0;
            byte_cnt_q  <= 10'd0;
            csum_q      <= 8'h00;
            tmo_q       <= TMO_LOAD;
            start_q     <= 1'b0;
            img_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            img_data_q  <= img_data_d;
            byte_cnt_q  <= byte_cnt_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            start_q     <= start_d;
            img_valid_q <= img_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
